// File: rtl/uart_baud_gen_pkg.sv
// Shared UART constants and the rounded baud divide helper used by the
// baud generator and the TX/RX paths that instantiate it.
package uart_baud_gen_pkg;

  localparam int CLK_FREQUENCE = 50_000_000;
  localparam int BAUD_RATE     = 115200;

  // Width of the debug view of the divider count, wide enough for any DIV.
  localparam int DBG_CNT_W = 32;

  // Clock cycles per tick, rounded to nearest: (clk + rate/2) / rate.
  function automatic int baud_div(input int clk, input int baud, input int os);
    int rate;
    rate = baud * os;
    return (clk + rate / 2) / rate;
  endfunction

endpackage

// File: rtl/uart_baud_gen_if.sv
// Tick interface between the baud generator and a UART TX/RX state machine.
interface uart_baud_gen_if;
  import uart_baud_gen_pkg::*;

  // bps_clk_en is a level run-enable driven by the master: high lets the
  // divider count, low holds it cleared. bps_clk is a one-cycle strobe from
  // the slave with no backpressure; the master must consume it the cycle it
  // is high. cnt_dbg mirrors the divider count for observation only.
  logic                 bps_clk_en;
  logic                 bps_clk;
  logic [DBG_CNT_W-1:0] cnt_dbg;

  modport master (output bps_clk_en, input bps_clk, input cnt_dbg);
  modport slave  (input bps_clk_en, output bps_clk, output cnt_dbg);

endinterface

// File: rtl/uart_baud_gen.sv
// Baud tick generator: divides clk_in down to a one-cycle bps_clk pulse at
// BAUD_RATE * OVERSAMPLING, restarting a full period whenever enabled.
module uart_baud_gen #(
  parameter int CLK_FREQUENCE = uart_baud_gen_pkg::CLK_FREQUENCE,
  parameter int BAUD_RATE     = uart_baud_gen_pkg::BAUD_RATE,
  parameter int OVERSAMPLING  = 1
) (
  input  logic           clk_in,
  input  logic           rst_n,
  uart_baud_gen_if.slave bus
);
  import uart_baud_gen_pkg::*;

  localparam int DIV = baud_div(CLK_FREQUENCE, BAUD_RATE, OVERSAMPLING);

  if (DIV < 2) begin : g_bad_div
    $error("uart_baud_gen: divide ratio %0d is below 2", DIV);
  end else begin : g_div
    localparam int            CW   = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;
    logic          bps_clk_q;

    // Dropping the enable discards any partial period, so the next frame
    // always starts from a full, phase-aligned bit time.
    always_ff @(posedge clk_in) begin
      if (!rst_n) begin
        cnt       <= '0;
        bps_clk_q <= 1'b0;
      end else if (!bus.bps_clk_en) begin
        cnt       <= '0;
        bps_clk_q <= 1'b0;
      end else if (cnt == LAST) begin
        cnt       <= '0;
        bps_clk_q <= 1'b1;
      end else begin
        cnt       <= cnt + 1'b1;
        bps_clk_q <= 1'b0;
      end
    end

    assign bus.bps_clk = bps_clk_q;
    assign bus.cnt_dbg = DBG_CNT_W'(cnt);
  end

endmodule

// File: tb/tb_uart_baud_gen.sv
// Directed bench for uart_baud_gen: a default-rate instance (DIV 434) and a
// 16x oversampled instance (DIV 27), checked with immediate assertions.
module tb_uart_baud_gen;
  import uart_baud_gen_pkg::*;

  logic clk;
  logic rst_n_a;
  logic rst_n_b;
  int   n_tests;
  int   n_fail;

  uart_baud_gen_if bus_a ();
  uart_baud_gen_if bus_b ();

  uart_baud_gen u_tx (
    .clk_in (clk),
    .rst_n  (rst_n_a),
    .bus    (bus_a.slave)
  );

  uart_baud_gen #(.OVERSAMPLING(16)) u_rx (
    .clk_in (clk),
    .rst_n  (rst_n_b),
    .bus    (bus_b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Cycles until the selected tick is seen high; -1 if none within max.
  task automatic wait_pulse(input bit sel, input int max, output int n);
    logic tick;
    n = 0;
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      n++;
      tick = sel ? bus_b.bps_clk : bus_a.bps_clk;
      if (tick === 1'b1) return;
    end
    n = -1;
  endtask

  // Step to the negedge where the TX divider shows target; returns success.
  task automatic advance_to_cnt(input int target, input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max; i++) begin
      if (bus_a.cnt_dbg === 32'(target)) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  task automatic count_highs(input bit sel, input int cycles, output int highs);
    highs = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if ((sel ? bus_b.bps_clk : bus_a.bps_clk) !== 1'b0) highs++;
    end
  endtask

  initial begin
    int n;
    int highs;
    bit ok;
    n_tests = 0;
    n_fail  = 0;
    rst_n_a = 1'b0;
    rst_n_b = 1'b0;
    bus_a.bps_clk_en = 1'b0;
    bus_b.bps_clk_en = 1'b0;

    // Reset and idle
    repeat (2) @(negedge clk);
    check("reset_bps_a", 32'(bus_a.bps_clk), 32'd0);
    check("reset_cnt_a", bus_a.cnt_dbg, 32'd0);
    check("reset_bps_b", 32'(bus_b.bps_clk), 32'd0);
    rst_n_a = 1'b1;
    rst_n_b = 1'b1;
    count_highs(1'b0, 1000, highs);
    check("idle_pulses", 32'(highs), 32'd0);
    check("idle_cnt", bus_a.cnt_dbg, 32'd0);

    // Default period: first pulse and ten more spaced 434 apart
    bus_a.bps_clk_en = 1'b1;
    wait_pulse(1'b0, 600, n);
    check("first_pulse", 32'(n), 32'd434);
    for (int k = 0; k < 10; k++) begin
      wait_pulse(1'b0, 600, n);
      check($sformatf("gap_%0d", k), 32'(n), 32'd434);
    end
    check("cnt_after_pulse", bus_a.cnt_dbg, 32'd0);

    // Enable gating at cnt 200 for 50 cycles
    advance_to_cnt(200, 600, ok);
    check("reach_cnt_200", 32'(ok), 32'd1);
    bus_a.bps_clk_en = 1'b0;
    count_highs(1'b0, 50, highs);
    check("gated_pulses", 32'(highs), 32'd0);
    check("gated_cnt", bus_a.cnt_dbg, 32'd0);
    bus_a.bps_clk_en = 1'b1;
    wait_pulse(1'b0, 600, n);
    check("reenable_pulse", 32'(n), 32'd434);

    // Enable dropped on the terminal-count edge
    advance_to_cnt(433, 600, ok);
    check("reach_cnt_433", 32'(ok), 32'd1);
    bus_a.bps_clk_en = 1'b0;
    @(negedge clk);
    check("collision_bps", 32'(bus_a.bps_clk), 32'd0);
    check("collision_cnt", bus_a.cnt_dbg, 32'd0);
    bus_a.bps_clk_en = 1'b1;
    wait_pulse(1'b0, 600, n);
    check("post_collision_pulse", 32'(n), 32'd434);

    // Reset while enabled at cnt 300
    advance_to_cnt(300, 600, ok);
    check("reach_cnt_300", 32'(ok), 32'd1);
    rst_n_a = 1'b0;
    @(negedge clk);
    check("midrst_bps", 32'(bus_a.bps_clk), 32'd0);
    check("midrst_cnt", bus_a.cnt_dbg, 32'd0);
    rst_n_a = 1'b1;
    wait_pulse(1'b0, 600, n);
    check("post_reset_pulse", 32'(n), 32'd434);

    // 16x oversampling instance: DIV 27, 16 pulses per 432 cycles
    bus_b.bps_clk_en = 1'b1;
    wait_pulse(1'b1, 100, n);
    check("os16_first_pulse", 32'(n), 32'd27);
    wait_pulse(1'b1, 100, n);
    check("os16_gap", 32'(n), 32'd27);
    count_highs(1'b1, 432, highs);
    check("os16_pulses_432", 32'(highs), 32'd16);

    // Divide helper, including the ratio that must be rejected
    check("div_default", 32'(baud_div(50_000_000, 115200, 1)), 32'd434);
    check("div_os16", 32'(baud_div(50_000_000, 115200, 16)), 32'd27);
    check("div_too_small", 32'(baud_div(100, 100, 1)), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
